// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment counter/display slice.
// Glyphs are {a,b,c,d,e,f,g}, active-low: a 0 lights the segment.
package ssd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] HEX_MAX = 4'd15;

  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b1100000;
  localparam logic [6:0] GLYPH_C     = 7'b0110001;
  localparam logic [6:0] GLYPH_D     = 7'b1000010;
  localparam logic [6:0] GLYPH_E     = 7'b0110000;
  localparam logic [6:0] GLYPH_F     = 7'b0111000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit digit to active-low seven-segment glyph decoder.
// Ports:
//   digit_i  4-bit digit value (0..F)
//   seg_o    segments {a,b,c,d,e,f,g}, active-low
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives seg_o and no latch is inferred.
    seg_o = GLYPH_BLANK;
    case (digit_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_counter_ssd.sv
// N-digit hex/BCD up/down counter with count prescaler and a
// time-multiplexed common-anode seven-segment scanner.
// Ports:
//   mdcs_clk       system clock
//   mdcs_rst       asynchronous active-low reset
//   mdcs_en        count enable, sampled on prescaler tick
//   mdcs_bcd       0 = hex digits, 1 = BCD digits
//   mdcs_down      0 = count up, 1 = count down
//   mdcs_clr       synchronous clear of count, prescaler and carry
//   mdcs_value     packed count, digit 0 in [3:0]
//   mdcs_carry     one-cycle pulse on wrap/borrow out of the MSD
//   mdcs_cc        segment cathodes {a..g}, active-low
//   mdcs_an        digit anodes, active-low, one-hot-low
//   mdcs_mode_led  {mdcs_bcd, mdcs_down}
module multi_digit_counter_ssd
  import ssd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CNT_DIV  = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  mdcs_clk,
  input  logic                  mdcs_rst,
  input  logic                  mdcs_en,
  input  logic                  mdcs_bcd,
  input  logic                  mdcs_down,
  input  logic                  mdcs_clr,
  output logic [4*DIGITS-1:0]   mdcs_value,
  output logic                  mdcs_carry,
  output logic [6:0]            mdcs_cc,
  output logic [DIGITS-1:0]     mdcs_an,
  output logic [1:0]            mdcs_mode_led
);

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // ---------------- prescaler ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          update;

  assign tick   = (presc_q == PRESC_LAST);
  // Clear wins over a coincident tick.
  assign update = tick & mdcs_en & ~mdcs_clr;

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick || mdcs_clr) presc_d = '0;
  end

  // ---------------- digit chain ----------------
  logic [DIGITS-1:0][3:0] value_q, value_d;
  logic [DIGITS-1:0]      wrap;   // digit would wrap/borrow if stepped
  logic [DIGITS-1:0]      step;   // digit steps on this edge
  logic [3:0]             max_val;
  logic                   carry_q, carry_d;

  assign max_val = mdcs_bcd ? BCD_MAX : HEX_MAX;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] nxt;
    logic       wrap_l;

    assign cur = value_q[i];

    always_comb begin
      nxt    = cur;
      wrap_l = 1'b0;
      if (!mdcs_down) begin
        // ">=" folds out-of-range BCD digits into the wrap case.
        if (cur >= max_val) begin
          nxt    = 4'd0;
          wrap_l = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == 4'd0) begin
          nxt    = max_val;
          wrap_l = 1'b1;
        end else if (cur > max_val) begin
          // Only reachable in BCD mode after a switch from hex.
          nxt = BCD_MAX;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end

    assign wrap[i] = wrap_l;

    // Ripple enable computed from the wrap vector alone, so there is no
    // combinational loop through step.
    if (i == 0) begin : g_lsd
      assign step[i] = update;
    end else begin : g_upper
      assign step[i] = update & (&wrap[i-1:0]);
    end

    assign value_d[i] = step[i] ? nxt : cur;
  end

  assign carry_d = update & (&wrap);

  always_ff @(posedge mdcs_clk or negedge mdcs_rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!mdcs_rst) begin
      presc_q <= '0;
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      carry_q <= carry_d;
      if (mdcs_clr) value_q <= '0;
      else          value_q <= value_d;
    end
  end

  // ---------------- scanner ----------------
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              slot_end;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        cc_q, seg_next;

  assign slot_end = (scan_q == SCAN_LAST);

  always_comb begin
    scan_d = slot_end ? '0 : scan_q + 1'b1;
    idx_d  = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  assign an_d = ~(DIGITS'(1) << idx_d);

  // Decode the digit at the new index so anode and glyph load on one edge.
  ssd_hex_decoder u_dec (
    .digit_i (value_q[idx_d]),
    .seg_o   (seg_next)
  );

  always_ff @(posedge mdcs_clk or negedge mdcs_rst) begin
    if (!mdcs_rst) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= ~DIGITS'(1);
      cc_q   <= GLYPH_0;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      if (slot_end) begin
        an_q <= an_d;
        cc_q <= seg_next;
      end
    end
  end

  assign mdcs_value    = value_q;
  assign mdcs_carry    = carry_q;
  assign mdcs_an       = an_q;
  assign mdcs_cc       = cc_q;
  assign mdcs_mode_led = {mdcs_bcd, mdcs_down};

endmodule

// File: tb/tb_multi_digit_counter_ssd.sv
// Directed bench for multi_digit_counter_ssd: a DIGITS=2, CNT_DIV=1,
// SCAN_DIV=4 instance for most scenarios plus a CNT_DIV=3 instance
// sharing the same inputs for the prescaler scenario.
module tb_multi_digit_counter_ssd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, bcd = 1'b0, down = 1'b0, clr = 1'b0;
  logic [7:0] value, value3;
  logic       carry, carry3;
  logic [6:0] cc, cc3;
  logic [1:0] an, an3;
  logic [1:0] led, led3;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] GA = 7'b0001000;

  multi_digit_counter_ssd #(.DIGITS(2), .CNT_DIV(1), .SCAN_DIV(4)) dut (
    .mdcs_clk(clk), .mdcs_rst(rst_n), .mdcs_en(en), .mdcs_bcd(bcd),
    .mdcs_down(down), .mdcs_clr(clr), .mdcs_value(value), .mdcs_carry(carry),
    .mdcs_cc(cc), .mdcs_an(an), .mdcs_mode_led(led)
  );

  multi_digit_counter_ssd #(.DIGITS(2), .CNT_DIV(3), .SCAN_DIV(4)) dut3 (
    .mdcs_clk(clk), .mdcs_rst(rst_n), .mdcs_en(en), .mdcs_bcd(bcd),
    .mdcs_down(down), .mdcs_clr(clr), .mdcs_value(value3), .mdcs_carry(carry3),
    .mdcs_cc(cc3), .mdcs_an(an3), .mdcs_mode_led(led3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    en  = 1'b0;
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (value !== 8'h00) begin bad++; $display("FAIL reset_value: got %h want 00", value); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", carry); end
    total++; if (an !== 2'b10) begin bad++; $display("FAIL reset_an: got %b want 10", an); end
    total++; if (cc !== G0) begin bad++; $display("FAIL reset_cc: got %b want %b", cc, G0); end
    total++; if (value3 !== 8'h00) begin bad++; $display("FAIL reset_value3: got %h want 00", value3); end
    bcd = 1'b1; down = 1'b0; #1;
    total++; if (led !== 2'b10) begin bad++; $display("FAIL mode_led_10: got %b want 10", led); end
    down = 1'b1; #1;
    total++; if (led !== 2'b11) begin bad++; $display("FAIL mode_led_11: got %b want 11", led); end
    down = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bcd_up();
    logic [7:0] e;
    int m;
    do_clear();
    bcd = 1'b1; down = 1'b0; en = 1'b1;
    for (int n = 1; n <= 101; n++) begin
      tick_n(1);
      m = n % 100;
      e = 8'((m / 10) * 16 + (m % 10));
      total++; if (value !== e) begin bad++; $display("FAIL bcd_up_value n=%0d: got %h want %h", n, value, e); end
      total++; if (carry !== (n == 100)) begin bad++; $display("FAIL bcd_up_carry n=%0d: got %b want %b", n, carry, (n == 100)); end
    end
    en = 1'b0;
  endtask

  task automatic test_hex_up();
    do_clear();
    bcd = 1'b0; down = 1'b0; en = 1'b1;
    tick_n(254);
    en = 1'b0;
    total++; if (value !== 8'hFE) begin bad++; $display("FAIL hex_preload: got %h want FE", value); end
    en = 1'b1;
    tick_n(1);
    total++; if (value !== 8'hFF || carry !== 1'b0) begin bad++; $display("FAIL hex_ff: got %h/%b want FF/0", value, carry); end
    tick_n(1);
    total++; if (value !== 8'h00 || carry !== 1'b1) begin bad++; $display("FAIL hex_wrap: got %h/%b want 00/1", value, carry); end
    tick_n(1);
    total++; if (value !== 8'h01 || carry !== 1'b0) begin bad++; $display("FAIL hex_after_wrap: got %h/%b want 01/0", value, carry); end
    en = 1'b0;
  endtask

  task automatic test_down();
    do_clear();
    bcd = 1'b1; down = 1'b1; en = 1'b1;
    tick_n(1);
    total++; if (value !== 8'h99 || carry !== 1'b1) begin bad++; $display("FAIL bcd_borrow: got %h/%b want 99/1", value, carry); end
    tick_n(1);
    total++; if (value !== 8'h98 || carry !== 1'b0) begin bad++; $display("FAIL bcd_down: got %h/%b want 98/0", value, carry); end
    do_clear();
    bcd = 1'b0; en = 1'b1;
    tick_n(1);
    total++; if (value !== 8'hFF || carry !== 1'b1) begin bad++; $display("FAIL hex_borrow: got %h/%b want FF/1", value, carry); end
    tick_n(1);
    total++; if (value !== 8'hFE || carry !== 1'b0) begin bad++; $display("FAIL hex_down: got %h/%b want FE/0", value, carry); end
    en = 1'b0; down = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_clear();
    bcd = 1'b0; down = 1'b0; en = 1'b1;
    tick_n(12);
    en = 1'b0;
    total++; if (value !== 8'h0C) begin bad++; $display("FAIL preload_0c: got %h want 0C", value); end
    bcd = 1'b1; en = 1'b1;
    tick_n(1);
    total++; if (value !== 8'h10) begin bad++; $display("FAIL oor_up: got %h want 10", value); end
    do_clear();
    bcd = 1'b0; down = 1'b0; en = 1'b1;
    tick_n(12);
    en = 1'b0; bcd = 1'b1; down = 1'b1;
    tick_n(3);
    total++; if (value !== 8'h0C) begin bad++; $display("FAIL mode_change_hold: got %h want 0C", value); end
    en = 1'b1;
    tick_n(1);
    total++; if (value !== 8'h09 || carry !== 1'b0) begin bad++; $display("FAIL oor_down: got %h/%b want 09/0", value, carry); end
    en = 1'b0; bcd = 1'b0; down = 1'b0;
    tick_n(20);
    total++; if (value !== 8'h09) begin bad++; $display("FAIL en_hold: got %h want 09", value); end
  endtask

  task automatic test_clear();
    int waited;
    do_clear();
    bcd = 1'b1; down = 1'b0; en = 1'b1;
    tick_n(37);
    total++; if (value !== 8'h37) begin bad++; $display("FAIL preload_37: got %h want 37", value); end
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    total++; if (value !== 8'h00 || carry !== 1'b0) begin bad++; $display("FAIL clr_on_tick: got %h/%b want 00/0", value, carry); end
    tick_n(1);
    total++; if (value !== 8'h01) begin bad++; $display("FAIL count_after_clr: got %h want 01", value); end
    waited = 0;
    while (an !== 2'b01 && waited < 20) begin
      tick_n(1);
      waited++;
    end
    total++; if (an !== 2'b01) begin bad++; $display("FAIL wait_an_01: got %b want 01", an); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (value !== 8'h00) begin bad++; $display("FAIL async_rst_value: got %h want 00", value); end
    total++; if (an !== 2'b10) begin bad++; $display("FAIL async_rst_an: got %b want 10", an); end
    total++; if (cc !== G0) begin bad++; $display("FAIL async_rst_cc: got %b want %b", cc, G0); end
    en = 1'b0;
    tick_n(1);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [1:0] last;
    int run;
    int changes;
    do_clear();
    bcd = 1'b0; down = 1'b0; en = 1'b1;
    tick_n(90);
    en = 1'b0;
    total++; if (value !== 8'h5A) begin bad++; $display("FAIL preload_5a: got %h want 5A", value); end
    tick_n(8);
    last = an;
    run = 0;
    changes = 0;
    for (int s = 0; s < 16; s++) begin
      tick_n(1);
      if (an == 2'b10) begin
        total++; if (cc !== GA) begin bad++; $display("FAIL scan_digit0 s=%0d: got %b want %b", s, cc, GA); end
      end else if (an == 2'b01) begin
        total++; if (cc !== G5) begin bad++; $display("FAIL scan_digit1 s=%0d: got %b want %b", s, cc, G5); end
      end else begin
        total++; bad++; $display("FAIL scan_an s=%0d: got %b want 10 or 01", s, an);
      end
      if (an === last) begin
        run++;
      end else begin
        if (changes > 0) begin
          total++; if (run !== 4) begin bad++; $display("FAIL scan_slot_len: got %0d want 4", run); end
        end
        changes++;
        run = 1;
        last = an;
      end
    end
    total++; if (changes < 3) begin bad++; $display("FAIL scan_changes: got %0d want >=3", changes); end
  endtask

  task automatic test_prescale();
    do_clear();
    bcd = 1'b0; down = 1'b0; en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick_n(1);
      total++; if (value3 !== 8'(k / 3)) begin bad++; $display("FAIL prescale k=%0d: got %h want %h", k, value3, 8'(k / 3)); end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bcd_up();
    test_hex_up();
    test_down();
    test_mode_switch();
    test_clear();
    test_scan();
    test_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_digit_counter_ssd.md
Name: multi_digit_counter_ssd

Overview:
Parametrised N-digit up/down counter with run-time hex/BCD mode, a built-in count prescaler and a time-multiplexed seven-segment scanner. Successor to the single-digit hex/BCD counter-plus-display block. Sits at board top level between the board clock and switches and the common-anode seven-segment bank, and drives every anode, where the earlier block drove only one.

Parameters:
DIGITS, 4, number of 4-bit digits counted and displayed (1..8)
CNT_DIV, 100000000, clock cycles per count tick (>=1; 1 = tick every cycle)
SCAN_DIV, 100000, clock cycles per display digit slot (>=1)

Ports:
mdcs_clk  in  1  system clock; the only clock
mdcs_rst  in  1  asynchronous, active-low reset
mdcs_en  in  1  count enable, sampled on tick
mdcs_bcd  in  1  0 = hex digits (0..F), 1 = BCD digits (0..9)
mdcs_down  in  1  0 = count up, 1 = count down
mdcs_clr  in  1  synchronous clear of count and prescaler
mdcs_value  out  4*DIGITS  packed count; digit 0 is in bits [3:0]
mdcs_carry  out  1  one-cycle pulse on full-width wrap (up) or borrow (down)
mdcs_cc  out  7  segment cathodes {a,b,c,d,e,f,g}, active-low
mdcs_an  out  DIGITS  digit anodes, active-low, one-hot-low
mdcs_mode_led  out  2  {mdcs_bcd, mdcs_down} mirrored combinationally

Behaviour:
- Reset (mdcs_rst=0, asynchronous): all digits 0, prescaler 0, scan counter 0, scan index 0, mdcs_carry 0, mdcs_an = all ones except bit0 = 0, mdcs_cc = 7'b0000001 (glyph "0").
- Prescaler: counts 0..CNT_DIV-1 and wraps. Internal tick is high for the single cycle in which the count equals CNT_DIV-1. The prescaler free-runs regardless of mdcs_en.
- Count update: happens on the clock edge where tick=1 and mdcs_en=1. Digits are chained LSD to MSD. A digit steps only if every lower digit wrapped or borrowed on that same update.
- Digit maximum: MAX = 9 in BCD mode, 15 in hex mode.
  - Up: digit==MAX -> 0 and carries to the next digit; else digit+1.
  - Down: digit==0 -> MAX and borrows from the next digit; else digit-1.
- Out-of-range BCD digit (value 10..15 while mdcs_bcd=1, e.g. after a mode switch): when stepped up it becomes 0 and carries; when stepped down it becomes 9. Digits that are not stepped are held unchanged.
- mdcs_carry: registered. It is 1 for exactly the cycle after an update that wrapped or borrowed out of the MSD, e.g. up from all-MAX to all-0, or down from all-0 to all-MAX. It is 0 otherwise.
- mdcs_clr=1: on the next edge, digits <= 0, prescaler <= 0, carry <= 0. Clear takes priority over a coincident tick. The scanner is unaffected.
- Mode and direction inputs are sampled only on update edges. Changing them between ticks has no effect on the stored value.
- Scanner: the scan counter runs 0..SCAN_DIV-1. On wrap, the scan index advances 0,1,..,DIGITS-1,0.
  - mdcs_an is registered, with bit[index] = 0 and all other bits 1.
  - mdcs_cc is registered, decoded from the digit selected by the new index in the same cycle, so anode and cathode always change on the same edge.
- Decoder glyphs (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Latency: mdcs_value reflects an update 1 cycle after the tick edge. The displayed glyph follows the value at the next scan slot of that digit.
- DIGITS=1: mdcs_an is constantly 0 after reset, and mdcs_carry fires on every single-digit wrap.

Decomposition:
- Shared constants file ssd_pkg: the 16 glyph encodings, the blank glyph 7'b1111111, and localparams for BCD_MAX=9 and HEX_MAX=15.
- One sub-module, ssd_hex_decoder: combinational 4-bit -> 7-bit active-low decode, instantiated once on the scan-selected digit.
- The counter chain is a generate loop over DIGITS inside the top. There is no per-digit sub-module.

Test Plan:
All scenarios use DIGITS=2, CNT_DIV=1, SCAN_DIV=4 unless noted.
1. Reset, then release with en=1, bcd=1, down=0 -> value counts 0x00, 0x01, ..., 0x09, 0x10, ..., 0x99, then 0x00 with mdcs_carry=1 for exactly 1 cycle.
2. Hex up: preload 0xFE by counting, en=1, bcd=0 -> 0xFF, then 0x00 with mdcs_carry pulse. A hex digit never exceeds F.
3. Down count from 0x00, bcd=1 -> 0x99 with carry pulse, then 0x98. Repeat with bcd=0 -> 0xFF, then 0xFE.
4. Counted to 0x0C in hex, switch bcd=1: down=0 gives 0x10; in a fresh run, down=1 from 0x0C gives 0x09. With en=0, value holds across 20 ticks.
5. clr asserted on a tick edge at value 0x37 -> value 0x00 next cycle, no carry. Assert mdcs_rst=0 mid-count (asynchronously, between edges) -> value 0x00, an=2'b10, cc=7'b0000001 immediately.
6. Scanner with value 0x5A: an alternates 10/01 every 4 cycles. cc is 0001000 while an=10 and 0100100 while an=01, and never shows a mismatched anode/glyph pair. CNT_DIV=3: value increments once every 3 cycles.
